// File: rtl/uart_stream_relay.sv
// Store-and-forward relay from the UART receiver to the UART transmitter.
// It holds bytes in a FIFO and releases them in pass-through, store-and-release or burst mode, and it keeps debug counters.
module uart_stream_relay #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic              release_pulse,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic [15:0]       rx_count,
  output logic [15:0]       sent_count,
  output logic [15:0]       overflow_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_STORE = 2'd1,
    MODE_BURST = 2'd2,
    MODE_HALT  = 2'd3
  } mode_e;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_BURST = (ADDR_W+1)'(BURST_LEN);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   w_remaining_nxt;
  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_tx_valid;
  logic [DATA_W-1:0] r_tx_data;
  logic [15:0]       r_rx_count;
  logic [15:0]       r_sent_count;
  logic [15:0]       r_ovf_count;

  mode_e w_mode;
  logic  w_empty;
  logic  w_full;
  logic  w_wr;
  logic  w_ovf;
  logic  w_hs;
  logic  w_free;
  logic  w_pop_en;
  logic  w_pop;

  assign w_mode  = mode_e'(mode);
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LP_DEPTH);
  assign w_wr    = in_valid & ~w_full;
  assign w_ovf   = in_valid & w_full;
  assign w_hs    = r_tx_valid & tx_ready;
  // The holding register can take a new byte in the same cycle that it hands its current byte to the transmitter.
  assign w_free  = ~r_tx_valid | w_hs;

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_pop_en        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        unique case (w_mode)
          MODE_PASS: w_state_nxt = ST_STREAM;
          MODE_STORE: begin
            if (release_pulse && !w_empty) begin
              w_state_nxt     = ST_DRAIN;
              w_remaining_nxt = r_level;
            end
          end
          MODE_BURST: begin
            if (r_level >= LP_BURST) begin
              w_state_nxt     = ST_DRAIN;
              w_remaining_nxt = LP_BURST;
            end
          end
          default: ;
        endcase
      end
      ST_STREAM: begin
        if (w_mode == MODE_PASS) w_pop_en = 1'b1;
        else if (!r_tx_valid)    w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        w_pop_en = (r_remaining != '0);
        if (r_remaining == '0 && !r_tx_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_pop = w_pop_en & ~w_empty & w_free;
    if (r_state == ST_DRAIN && w_pop) w_remaining_nxt = r_remaining - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_pop) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= r_mem[r_rd_ptr];
    end else if (w_hs) begin
      r_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_count   <= '0;
      r_sent_count <= '0;
      r_ovf_count  <= '0;
    end else begin
      if (w_wr) r_rx_count <= r_rx_count + 16'd1;
      if (w_hs) r_sent_count <= r_sent_count + 16'd1;
      if (w_ovf && r_ovf_count != 16'hFFFF) r_ovf_count <= r_ovf_count + 16'd1;
    end
  end

  assign tx_data        = r_tx_data;
  assign tx_valid       = r_tx_valid;
  assign level          = r_level;
  assign empty          = w_empty;
  assign full           = w_full;
  assign rx_count       = r_rx_count;
  assign sent_count     = r_sent_count;
  assign overflow_count = r_ovf_count;
  assign state_dbg      = r_state;

endmodule
